// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: receive-sequencer state encoding and default baud timing.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_t;

  // 50 MHz system clock at 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises the line, finds the start bit, pulses the shift
// register at mid-bit for data+parity, then checks the stop bit and reports status.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  input  logic parity,
  input  logic parity_int,
  output logic rx_bit,
  output logic shift,
  output logic busy,
  output logic rx_done,
  output logic parity_error,
  output logic framing_error
);

  localparam logic [CNT_W-1:0] HALF_LIMIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LIMIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam int               BIT_W      = $clog2(WORD_LENGTH + 2);
  // bitcnt value seen at the final (parity) shift
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WORD_LENGTH);

  logic             sync1_reg, sync2_reg, hist_reg;
  uart_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [BIT_W-1:0] bitcnt_reg, bitcnt_next;
  logic             perr_reg, perr_next;
  logic             ferr_reg, ferr_next;
  logic             tick;
  logic             fall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      hist_reg   <= 1'b1;
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bitcnt_reg <= '0;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
    end else begin
      sync1_reg  <= rx_in;
      sync2_reg  <= sync1_reg;
      hist_reg   <= sync2_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bitcnt_reg <= bitcnt_next;
      perr_reg   <= perr_next;
      ferr_reg   <= ferr_next;
    end
  end

  assign fall = hist_reg & ~sync2_reg;

  always_comb begin
    tick = 1'b0;
    case (state_reg)
      START:      tick = (cnt_reg == HALF_LIMIT);
      DATA, STOP: tick = (cnt_reg == FULL_LIMIT);
      default:    tick = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    bitcnt_next = bitcnt_reg;
    perr_next   = perr_reg;
    ferr_next   = ferr_reg;
    shift       = 1'b0;
    rx_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fall) state_next = START;
      end
      START: begin
        if (tick) begin
          if (!sync2_reg) begin
            state_next  = DATA;
            bitcnt_next = '0;
            perr_next   = 1'b0;
            ferr_next   = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift       = 1'b1;
          bitcnt_next = bitcnt_reg + 1'b1;
          if (bitcnt_reg == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          ferr_next  = ~sync2_reg;
          perr_next  = parity ^ parity_int;
          state_next = DONE;
        end
      end
      DONE: begin
        rx_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter restarts on each state change and at every tick so DATA bits stay one period apart
  always_comb begin
    cnt_next = cnt_reg;
    if ((state_next != state_reg) || tick) begin
      cnt_next = '0;
    end else if (state_reg == START || state_reg == DATA || state_reg == STOP) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign rx_bit        = sync2_reg;
  assign busy          = (state_reg != IDLE);
  assign parity_error  = perr_reg;
  assign framing_error = ferr_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are queued with their expected outcome when sent,
// and a negedge monitor checks every shift pulse and rx_done against that queue.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
  localparam int WL  = 8;
  // raw start edge to rx_done: half bit + data/parity/stop bits + sync and edge detect
  localparam int DONE_LAT = CPB / 2 + (WL + 2) * CPB + 3;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic rx_in;
  logic parity, parity_int;
  logic rx_bit, shift, busy, rx_done, parity_error, framing_error;

  logic [WL:0] sr = '0;
  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          shifts_in_frame = 0;
  int          last_shift_cyc = 0;
  logic        last_perr = 1'b0;
  logic        last_ferr = 1'b0;

  uart_rx_ctrl #(
    .WORD_LENGTH (WL),
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .parity       (parity),
    .parity_int   (parity_int),
    .rx_bit       (rx_bit),
    .shift        (shift),
    .busy         (busy),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the neighbouring RX shift register: LSB-first data, parity bit last
  always @(posedge clk) if (shift) sr <= {rx_bit, sr[WL:1]};
  assign parity     = sr[WL];
  assign parity_int = ^sr[WL-1:0];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: shift spacing and frame completion against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      shifts_in_frame = 0;
    end else begin
      if (shift) begin
        if (shifts_in_frame > 0) check("shift_spacing", cyc - last_shift_cyc, CPB);
        last_shift_cyc = cyc;
        shifts_in_frame++;
      end
      if (rx_done) begin
        check("done_no_shift", int'(shift), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rx_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("frame data=%02h perr=%0b ferr=%0b shifts=%0d (exp %02h/%0b/%0b)",
                   sr[WL-1:0], parity_error, framing_error, shifts_in_frame, e.data, e.perr, e.ferr);
          check("shift_count", shifts_in_frame, WL + 1);
          check("data", int'(sr[WL-1:0]), int'(e.data));
          check("parity_error", int'(parity_error), int'(e.perr));
          check("framing_error", int'(framing_error), int'(e.ferr));
          check("done_latency", cyc - e.start_cyc, DONE_LAT);
        end
        shifts_in_frame = 0;
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    exp_t e;
    e.data      = d;
    e.perr      = pbit ^ (^d);
    e.ferr      = ~stop;
    e.start_cyc = cyc;
    last_perr   = e.perr;
    last_ferr   = e.ferr;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < WL; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_in_time", int'(n < 3000), 1);
  endtask

  initial begin
    logic [7:0] d;
    logic       pbit, stop;
    int         gap;

    reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_shift", int'(shift), 0);
    check("reset_rx_done", int'(rx_done), 0);
    check("reset_perr", int'(parity_error), 0);
    check("reset_ferr", int'(framing_error), 0);
    check("reset_rx_bit", int'(rx_bit), 1);
    reset = 1'b1;
    idle(10);

    // Clean frame, wrong parity, then framing error followed by a held-low line
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(20);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (120) @(posedge clk);
    #1;
    check("break_queue_empty", exp_q.size(), 0);
    check("break_not_busy", int'(busy), 0);
    idle(20);

    // Short low glitch must be rejected without disturbing the sticky flags
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    check("glitch_busy", int'(busy), 0);
    check("glitch_shifts", shifts_in_frame, 0);
    check("glitch_perr_kept", int'(parity_error), int'(last_perr));
    check("glitch_ferr_kept", int'(framing_error), int'(last_ferr));

    // Reset during DATA after four shifts discards the frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    check("shifts_before_reset", shifts_in_frame, 4);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_shift", int'(shift), 0);
    check("midreset_perr", int'(parity_error), 0);
    check("midreset_ferr", int'(framing_error), 0);
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(10);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(10);

    // Back-to-back frames with no idle gap
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    idle(10);

    // Random frames: occasional bad parity or bad stop bit, random gaps
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom_range(0, 255));
      pbit = (^d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, pbit, stop);
      gap = stop ? $urandom_range(0, 20) : $urandom_range(5, 20);
      if (gap > 0) idle(gap);
    end
    idle(5);

    wait_drain();
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
